mem_dmem_ctrl: RTL
==================

Name: mem_dmem_ctrl

Overview:
- Memory-stage data-memory initiator for the pipelined RV32I core. Sits between EX_MEM and the data cache port.
- Issues word-aligned read/write requests with byte masks and holds them until the cache responds.
- Sign/zero-extends load data into the word written to MEM_WB, and drives MEM_WB's load enable and the global pipeline stall.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  a valid instruction occupies MEM
- mem_read_i  in  1  instruction is a load (ctrl.mem_read)
- mem_write_i  in  1  instruction is a store (ctrl.mem_write)
- funct3_i  in  3  load/store width code (rv32i_types load/store funct3)
- addr_i  in  32  byte address from ALU
- wdata_i  in  32  store data (rs2)
- ext_stall_i  in  1  stall request from elsewhere (e.g. I-fetch miss)
- dmem_read  out  1  cache read request
- dmem_write  out  1  cache write request
- dmem_address  out  32  {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-shifted store data
- dmem_wmask  out  4  byte-enable mask, also used as the read mask
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  one-cycle cache completion
- rdata_o  out  32  extended load data, fed to mem_rdata_i_MEM_WB
- rmask_o / wmask_o  out  4 each  rvfi masks for the completed access
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM
- mem_wb_load_o  out  1  load enable for MEM_WB
- misaligned_o  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE; dmem_read/write 0; dmem_address/wdata/wmask 0; rdata_o 0; rmask_o/wmask_o 0; misaligned_o 0.
  - stall_o = 0 and mem_wb_load_o = !ext_stall_i.
- Offset: off = addr_i[1:0]. Base mask by width: byte 4'b0001, half 4'b0011, word 4'b1111.
  - mask = base << off.
  - dmem_wdata = wdata_i << (8*off); for sb/sh the low byte/half is replicated into the selected lanes.
- Misaligned access: half with off[0]=1, or word with off!=0.
  - No request is issued; misaligned_o=1 for that cycle.
  - The instruction passes as a no-op: rdata_o=0, masks 0, no stall.
- FSM states IDLE, BUSY, DONE:
  - IDLE, valid_i & (mem_read_i|mem_write_i) & aligned:
    - stall_o=1 combinationally.
    - Register address, wdata, mask, funct3 and offset.
    - Set dmem_read (load) or dmem_write (store); go to BUSY.
    - If mem_read_i and mem_write_i are both set, read wins.
  - IDLE, otherwise: stall_o=0; no request.
  - BUSY:
    - Hold the request and all registered request fields stable.
    - stall_o=1.
    - On dmem_resp: drop the request next cycle, register the extended rdata and masks, go to DONE.
    - A resp in the first BUSY cycle is legal (zero-wait cache).
  - DONE:
    - stall_o=0; rdata_o/rmask_o/wmask_o valid.
    - If ext_stall_i=1, stay in DONE and hold rdata_o; no new request is issued.
    - Else go to IDLE.
- Minimum load/store cost: 2 stall cycles (IDLE, BUSY); completion data appears the cycle after dmem_resp.
- mem_wb_load_o = !stall_o & !ext_stall_i, in every state.
- Load extension on dmem_rdata >> (8*off):
  - lb: sign-extend bit 7; lbu: zero-extend.
  - lh: sign-extend bit 15; lhu: zero-extend.
  - lw: passthrough.
  - Store completion: rdata_o=0, rmask_o=0, wmask_o=mask.
- dmem_resp in IDLE or DONE is ignored.
- rst in BUSY returns to IDLE; the request is dropped at that clock edge, and a late resp is ignored.
- valid_i=0 with a mem op issues no request.

Decomposition:
- rv32i_types: add dmem_state_t {IDLE,BUSY,DONE}; reuse the existing load_funct3_t/store_funct3_t.
- Sub-module dmem_align (combinational): mask generation, store lane shift, load extension, misalignment detect.

Test Plan:
- lw at 0x0000_1004, cache responds 3 cycles after dmem_read -> dmem_address 0x1004, wmask 1111; stall_o high until resp; rdata_o=0xDEADBEEF the cycle after resp; mem_wb_load_o=1 that cycle.
- lb at 0x1003, dmem_rdata 0x80FF_0000 -> rmask 1000; rdata_o 0xFFFF_FF80. lbu at the same address -> 0x0000_0080.
- sh of wdata 0x1234_ABCD at 0x2002 -> dmem_write=1, wmask 1100, dmem_wdata[31:16]=0xABCD; zero-wait resp gives exactly 2 stall cycles.
- lw at 0x3002 -> misaligned_o pulse; no dmem_read; stall_o=0; rdata_o=0.
- ext_stall_i=1 during DONE for 4 cycles -> no new request, rdata_o held, mem_wb_load_o=0; it releases when ext_stall_i falls.
- rst asserted in BUSY, with dmem_resp arriving 1 cycle later -> dmem_read=0 after the edge; state IDLE; resp ignored; rdata_o stays 0.

Source files
------------

// File: rtl/mem_dmem_ctrl_pkg.sv
// rtl/mem_dmem_ctrl_pkg.sv - shared types for the memory-stage data-memory initiator
package mem_dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   // Access width lives in funct3[1:0] for both loads and stores.
   function automatic logic [3:0] base_mask(input logic [1:0] width);
      case (width)
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_dmem_align.sv
// rtl/mem_dmem_align.sv - byte-lane mask, store lane placement, load extension, misalign detect
module dmem_align
   import mem_dmem_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   output logic [3:0]  mask,
   output logic [31:0] wdata_lane,
   output logic        misaligned,
   input  logic [2:0]  ext_funct3,
   input  logic [1:0]  ext_off,
   input  logic [31:0] rdata,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   always_comb begin
      mask = base_mask(funct3[1:0]) << off;
      case (funct3[1:0])
         2'b00: begin
            wdata_lane = {4{wdata[7:0]}};
            misaligned = 1'b0;
         end
         2'b01: begin
            wdata_lane = {2{wdata[15:0]}};
            misaligned = off[0];
         end
         default: begin
            wdata_lane = wdata;
            misaligned = (off != 2'b00);
         end
      endcase
   end

   // Load extension works on the registered width/offset of the outstanding request.
   always_comb begin
      shifted = rdata >> {ext_off, 3'b000};
      case (load_funct3_t'(ext_funct3))
         lb:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         lbu:     rdata_ext = {24'd0, shifted[7:0]};
         lh:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         lhu:     rdata_ext = {16'd0, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/mem_dmem_ctrl.sv
// rtl/mem_dmem_ctrl.sv - MEM-stage data cache initiator with load extension and pipeline stall
module mem_dmem_ctrl
   import mem_dmem_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic            mem_read_i,
   input  logic            mem_write_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic            ext_stall_i,
   output logic            dmem_read,
   output logic            dmem_write,
   output logic [XLEN-1:0] dmem_address,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wmask,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_resp,
   output logic [XLEN-1:0] rdata_o,
   output logic [3:0]      rmask_o,
   output logic [3:0]      wmask_o,
   output logic            stall_o,
   output logic            mem_wb_load_o,
   output logic            misaligned_o
);

   dmem_state_t     state;
   logic [2:0]      funct3_q;
   logic [1:0]      off_q;
   logic [3:0]      req_mask;
   logic [XLEN-1:0] req_wdata;
   logic [XLEN-1:0] ext_rdata;
   logic            misaligned;
   logic            mem_op;
   logic            start;

   dmem_align u_align (
      .funct3     (funct3_i),
      .off        (addr_i[1:0]),
      .wdata      (wdata_i),
      .mask       (req_mask),
      .wdata_lane (req_wdata),
      .misaligned (misaligned),
      .ext_funct3 (funct3_q),
      .ext_off    (off_q),
      .rdata      (dmem_rdata),
      .rdata_ext  (ext_rdata)
   );

   assign mem_op        = valid_i && (mem_read_i || mem_write_i);
   assign start         = (state == IDLE) && mem_op && !misaligned;
   assign stall_o       = !rst && (start || state == BUSY);
   assign mem_wb_load_o = !stall_o && !ext_stall_i;
   assign misaligned_o  = !rst && (state == IDLE) && mem_op && misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dmem_read    <= 1'b0;
         dmem_write   <= 1'b0;
         dmem_address <= '0;
         dmem_wdata   <= '0;
         dmem_wmask   <= 4'b0000;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         rdata_o      <= '0;
         rmask_o      <= 4'b0000;
         wmask_o      <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dmem_address <= {addr_i[XLEN-1:2], 2'b00};
                  dmem_wdata   <= req_wdata;
                  dmem_wmask   <= req_mask;
                  funct3_q     <= funct3_i;
                  off_q        <= addr_i[1:0];
                  dmem_read    <= mem_read_i;
                  dmem_write   <= !mem_read_i;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               if (dmem_resp) begin
                  dmem_read  <= 1'b0;
                  dmem_write <= 1'b0;
                  if (dmem_read) begin
                     rdata_o <= ext_rdata;
                     rmask_o <= dmem_wmask;
                     wmask_o <= 4'b0000;
                  end else begin
                     rdata_o <= '0;
                     rmask_o <= 4'b0000;
                     wmask_o <= dmem_wmask;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               // Completion data stays visible until MEM_WB is free to take it.
               if (!ext_stall_i) begin
                  rdata_o <= '0;
                  rmask_o <= 4'b0000;
                  wmask_o <= 4'b0000;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
